// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and data.
// Captures one request, issues it over valid/ready, routes the response back.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic          we1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          sel,
  output logic          mem_valid,
  input  logic          mem_ready,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic          rsp0_valid,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp_data
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_e;

  state_e        state_q, state_d;
  logic          sel_q, sel_d;
  logic          last_q, last_d;
  logic          mem_valid_q, mem_valid_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          mem_we_q, mem_we_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          gnt0_q, gnt0_d;
  logic          gnt1_q, gnt1_d;
  logic          rsp0_q, rsp0_d;
  logic          rsp1_q, rsp1_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          win;

  // Data wins alone, or on a tie when fetch was served last.
  assign win = req1 & (~req0 | ~last_q);

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    last_d      = last_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    rsp_data_d  = rsp_data_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    rsp0_d      = 1'b0;
    rsp1_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          state_d     = ISSUE;
          sel_d       = win;
          mem_valid_d = 1'b1;
          mem_addr_d  = win ? addr1 : addr0;
          mem_we_d    = win & we1;
          mem_wdata_d = win ? wdata1 : '0;
          gnt0_d      = ~win;
          gnt1_d      = win;
        end
      end
      ISSUE: begin
        if (mem_ready) begin
          state_d     = WAIT;
          mem_valid_d = 1'b0;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_d    = IDLE;
          rsp_data_d = mem_rdata;
          rsp0_d     = ~sel_q;
          rsp1_d     = sel_q;
          last_d     = sel_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      last_q      <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rsp0_q      <= 1'b0;
      rsp1_q      <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      rsp0_q      <= rsp0_d;
      rsp1_q      <= rsp1_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign gnt0       = gnt0_q;
  assign gnt1       = gnt1_q;
  assign sel        = sel_q;
  assign mem_valid  = mem_valid_q;
  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
  assign rsp0_valid = rsp0_q;
  assign rsp1_valid = rsp1_q;
  assign rsp_data   = rsp_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic
// checked against a transaction-level round-robin model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0;
  logic        we1 = 1'b0;
  logic [31:0] wdata1 = '0;
  logic        gnt0, gnt1, sel, mem_valid, mem_we;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr, mem_wdata, rsp_data;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        rsp0_valid, rsp1_valid;

  int passed = 0;
  int total  = 0;
  bit last_w = 1'b0;
  logic [31:0] last_rsp = '0;

  mem_port_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .we1(we1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .sel(sel),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic bit pick(bit r0, bit r1, bit prev);
    if (r0 && r1) return !prev;
    return r1;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    step(); step();
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_sel", sel, 0);
    chk("rst_valid", mem_valid, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rsp0", rsp0_valid, 0);
    chk("rst_rsp1", rsp1_valid, 0);
    chk("rst_rdata", rsp_data, 0);
    rst_n = 1'b1;
    last_w = 1'b0;
    last_rsp = '0;
  endtask

  // mode: 0 keep reqs, 1 winner drops req after gnt, 2 all drop
  task automatic do_txn(input int mode, input int stall, input int rdly,
                        input logic [31:0] rd, output bit w);
    logic [31:0] ea, ed;
    logic        ew;
    w  = pick(req0, req1, last_w);
    ea = w ? addr1 : addr0;
    ew = w ? we1 : 1'b0;
    ed = w ? wdata1 : 32'h0;
    step();
    chk("gnt0", gnt0, !w);
    chk("gnt1", gnt1, w);
    chk("sel", sel, w);
    chk("valid", mem_valid, 1);
    chk("addr", mem_addr, ea);
    chk("we", mem_we, ew);
    chk("wdata", mem_wdata, ed);
    chk("rsp_idle0", rsp0_valid, 0);
    chk("rsp_idle1", rsp1_valid, 0);
    if (mode == 2) begin
      req0 = 1'b0; req1 = 1'b0;
    end else if (mode == 1) begin
      if (w) req1 = 1'b0;
      else req0 = 1'b0;
    end
    mem_ready = (stall == 0);
    for (int i = 0; i < stall; i++) begin
      step();
      chk("stall_valid", mem_valid, 1);
      chk("stall_gnt", gnt0 | gnt1, 0);
      chk("stall_addr", mem_addr, ea);
      chk("stall_we", mem_we, ew);
      chk("stall_wdata", mem_wdata, ed);
      if (i == stall - 1) mem_ready = 1'b1;
    end
    step();
    mem_ready = 1'b0;
    chk("wait_valid", mem_valid, 0);
    for (int j = 0; j < rdly; j++) begin
      step();
      chk("wait_rsp", rsp0_valid | rsp1_valid, 0);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = rd;
    step();
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    chk("rsp0", rsp0_valid, !w);
    chk("rsp1", rsp1_valid, w);
    chk("rsp_data", rsp_data, rd);
    last_w   = w;
    last_rsp = rd;
  endtask

  initial begin
    bit w;
    bit exp_order [4];
    bit p0, p1;
    exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};

    do_reset();

    // stray response while idle
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFFFF_FFFF;
    step();
    mem_rvalid = 1'b0;
    step();
    chk("stray_data", rsp_data, 0);
    chk("stray_rsp", rsp0_valid | rsp1_valid, 0);
    chk("stray_valid", mem_valid, 0);

    // fetch only
    req0 = 1'b1; addr0 = 32'h0000_0040;
    do_txn(1, 0, 0, 32'hDEAD_BEEF, w);
    chk("fetch_w", w, 0);

    // data write
    req1 = 1'b1; we1 = 1'b1;
    addr1 = 32'h0000_0100; wdata1 = 32'h1234_5678;
    do_txn(1, 0, 1, 32'h0BAD_F00D, w);
    chk("write_w", w, 1);
    we1 = 1'b0;

    // contention from reset
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    addr0 = 32'h0000_1000; addr1 = 32'h0000_2000;
    we1 = 1'b1; wdata1 = 32'hCAFE_0001;
    for (int k = 0; k < 4; k++) begin
      do_txn(k == 3 ? 2 : 0, 0, 0, 32'h100 + k, w);
      chk("rr_order", w, exp_order[k]);
    end
    step();
    chk("rr_quiet", mem_valid, 0);

    // backpressure
    req0 = 1'b1; addr0 = 32'h0000_0ABC;
    do_txn(1, 5, 0, 32'h5555_AAAA, w);

    // reset in WAIT
    req1 = 1'b1; addr1 = 32'h0000_0300; we1 = 1'b0;
    wdata1 = 32'h7777_7777;
    step();
    req1 = 1'b0;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", mem_valid, 0);
    chk("abort_addr", mem_addr, 0);
    chk("abort_wdata", mem_wdata, 0);
    chk("abort_sel", sel, 0);
    chk("abort_rdata", rsp_data, 0);
    step();
    rst_n = 1'b1;
    last_w = 1'b0;
    step();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h9999_9999;
    step();
    mem_rvalid = 1'b0;
    step();
    chk("late_rsp", rsp0_valid | rsp1_valid, 0);
    chk("late_data", rsp_data, 0);
    last_rsp = '0;

    // random traffic
    p0 = 1'b0; p1 = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (!p0 && $urandom_range(0, 1) == 1) begin
        p0 = 1'b1; addr0 = $urandom;
      end
      if (!p1 && $urandom_range(0, 1) == 1) begin
        p1 = 1'b1; addr1 = $urandom;
        we1 = 1'($urandom_range(0, 1)); wdata1 = $urandom;
      end
      if (!p0 && !p1) begin
        p0 = 1'b1; addr0 = $urandom;
      end
      req0 = p0; req1 = p1;
      do_txn(1, $urandom_range(0, 3), $urandom_range(0, 2), $urandom, w);
      if (w) p1 = 1'b0;
      else p0 = 1'b0;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter sharing the processor's single memory port between instruction fetch (requester 0) and data load/store (requester 1). It captures one request at a time, drives the 32-bit address/data mux select, and issues the access over a valid/ready handshake. It waits for the memory's response and routes it back to the owning requester. It sits between the fetch/MEM stages and the unified memory interface.

## Interface
- AW, 32, address width
- DW, 32, data width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req0 / req1  in  1  request from fetch / data stage; held with payload until matching gnt
- addr0 / addr1  in  AW  request address
- we1  in  1  data-stage write enable (fetch is always read)
- wdata1  in  DW  data-stage write data
- gnt0 / gnt1  out  1  one-cycle pulse: request captured
- sel  out  1  mux select of the granted requester (0 = fetch, 1 = data)
- mem_valid  out  1  access presented to memory
- mem_ready  in  1  memory accepts access when high with mem_valid
- mem_addr  out  AW  registered address of captured request
- mem_we  out  1  registered write enable (0 when sel = 0)
- mem_wdata  out  DW  registered write data (0 when sel = 0)
- mem_rvalid  in  1  response/write-ack strobe
- mem_rdata  in  DW  read data, valid with mem_rvalid
- rsp0_valid / rsp1_valid  out  1  one-cycle response pulse to owner
- rsp_data  out  DW  registered copy of mem_rdata

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE: if any req is high, pick a winner, register sel, mem_addr, mem_we, and mem_wdata, and go to ISSUE. Otherwise stay.
- Arbitration: a lone request wins. If both request, the requester not granted most recently wins (round-robin). The last-grant pointer resets to 0, so data (1) wins the first tie.
- ISSUE: mem_valid = 1, and gnt of the winner is high in the first ISSUE cycle only. Payload is held stable. When mem_valid && mem_ready, go to WAIT. req inputs are ignored.
- WAIT: mem_valid = 0. On mem_rvalid, register rsp_data <= mem_rdata, pulse rsp{sel}_valid next cycle, update the last-grant pointer, and go to IDLE.
- Writes also wait for mem_rvalid (write ack). For writes, rsp_data carries whatever mem_rdata held.
- mem_rvalid is ignored outside WAIT, so stray strobes have no effect.
- Requesters must not change addr/we/wdata while req is high and gnt has not yet pulsed.
- sel holds its last value in IDLE.

## Timing
- Reset (async, rst_n low) values:
  - State IDLE, sel = 0, last-grant = 0.
  - mem_valid = 0, mem_addr = 0, mem_we = 0, mem_wdata = 0.
  - gnt0 = gnt1 = 0, rsp0_valid = rsp1_valid = 0, rsp_data = 0.
- All outputs are registered.
- Request sampled at edge N → mem_valid and gnt high in cycle N+1.
- If mem_ready is high in cycle N+1 → WAIT in N+2.
- mem_rvalid in cycle N+2 → rsp valid and state IDLE in N+3.
- The next request can be captured at edge N+3. Minimum occupancy is 3 cycles per access, and a new access starts every 3 cycles.
- mem_ready low stalls ISSUE indefinitely with all mem_* outputs stable.
- A rsp pulse in the same cycle as the IDLE state is normal. Capture of the next request proceeds in parallel.
- Reset asserted in ISSUE or WAIT aborts the transaction: no gnt, no rsp, outputs cleared immediately. A late mem_rvalid after reset is ignored.
- Simultaneous req0 and req1 rising in the same cycle resolve purely by the pointer. The loser keeps req high and is served next, so worst-case wait is one transaction.

## Test plan
- Fetch only: req0 = 1, addr0 = 0x0000_0040, mem_ready = 1, rvalid with rdata = 0xDEAD_BEEF one cycle later → gnt0 at N+1, mem_addr = 0x40, sel = 0, rsp0_valid at N+3 with rsp_data = 0xDEADBEEF.
- Data write: req1, we1 = 1, addr1 = 0x100, wdata1 = 0x1234_5678 → mem_we = 1, mem_wdata = 0x12345678, sel = 1, rsp1_valid after ack, rsp0_valid never pulses.
- Contention: req0 and req1 held high from reset for 4 transactions → grant order 1, 0, 1, 0, each gnt a single-cycle pulse.
- Backpressure: mem_ready low for 5 cycles in ISSUE → mem_valid high for 6 cycles with mem_addr, mem_we, and mem_wdata unchanged, and gnt pulses only once.
- Reset mid-WAIT: assert rst_n = 0 in WAIT, release, then pulse mem_rvalid → all outputs 0 immediately and no rsp pulse.
- Stray response: mem_rvalid = 1 with rdata = 0xFFFF_FFFF while IDLE → rsp_data stays 0 and no rsp pulse.
